// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the MIPS fetch stage.
//
// Owns the PC register, fetches instruction words over a req/ack handshake,
// presents each word to decode over a valid/ready handshake, and applies
// redirects (branch, jump, jump-register) arriving from execute.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   imem_req/addr   fetch request and address (addr tracks pc)
//   imem_ack/rdata  memory accept; rdata valid in the ack cycle
//   instr_valid     fetched word available to decode
//   instr/instr_pc  fetched word and its address
//   instr_ready     decode consumes instr when valid & ready
//   redir_*         one-cycle redirect request and its operands
//   pc              current PC register
//   fetch_err       sticky: a request went unacknowledged for TIMEOUT cycles
//   align_err       one-cycle pulse: jump-register target was misaligned
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc,
    input  logic [15:0] redir_imm,
    input  logic [25:0] redir_target26,
    input  logic [31:0] redir_reg,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic [31:0] instr_n;
    logic [31:0] instr_pc_n;
    logic        kill, kill_n;
    logic [7:0]  wait_cnt, wait_cnt_n;
    logic        fetch_err_n;
    logic        align_err_n;

    logic [31:0] p4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        take;

    // Redirect target formation; type 11 is not a redirect.
    always_comb begin
        p4     = redir_pc + 32'd4;
        br_off = {{14{redir_imm[15]}}, redir_imm, 2'b00};
        target = p4;
        case (redir_type)
            2'b00:   target = p4 + br_off;
            2'b01:   target = {p4[31:28], redir_target26, 2'b00};
            2'b10:   target = {redir_reg[31:2], 2'b00};
            default: target = p4;
        endcase
        take = redir_valid && (redir_type != 2'b11);
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_n     = instr;
        instr_pc_n  = instr_pc;
        kill_n      = kill;
        wait_cnt_n  = wait_cnt;
        fetch_err_n = fetch_err;
        align_err_n = redir_valid && (redir_type == 2'b10) && (redir_reg[1:0] != 2'b00);

        imem_req    = (state == REQ);
        imem_addr   = pc;
        instr_valid = (state == HOLD);

        case (state)
            IDLE: begin
                state_n = REQ;
                if (take) pc_n = target;
            end
            REQ: begin
                if (imem_ack) begin
                    wait_cnt_n = '0;
                    // A redirect in the ack cycle and a pending kill both
                    // drop the returned word; the request is reissued at pc_n.
                    if (take) begin
                        pc_n   = target;
                        kill_n = 1'b0;
                    end else if (kill) begin
                        kill_n = 1'b0;
                    end else begin
                        instr_n    = imem_rdata;
                        instr_pc_n = pc;
                        pc_n       = pc + 32'd4;
                        state_n    = HOLD;
                    end
                end else begin
                    // The outstanding request cannot be withdrawn, so its
                    // eventual ack must be discarded.
                    if (take) begin
                        pc_n   = target;
                        kill_n = 1'b1;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        fetch_err_n = 1'b1;
                        wait_cnt_n  = '0;
                    end else begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                wait_cnt_n = '0;
                if (take) begin
                    pc_n    = target;
                    state_n = REQ;
                end else if (instr_ready) begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            instr_pc  <= '0;
            kill      <= 1'b0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            instr     <= instr_n;
            instr_pc  <= instr_pc_n;
            kill      <= kill_n;
            wait_cnt  <= wait_cnt_n;
            fetch_err <= fetch_err_n;
            align_err <= align_err_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_pc_sequencer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [31:0] redir_pc;
    logic [15:0] redir_imm;
    logic [25:0] redir_target26;
    logic [31:0] redir_reg;
    logic [31:0] pc;
    logic        fetch_err;
    logic        align_err;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_target26(redir_target26), .redir_reg(redir_reg),
        .pc(pc), .fetch_err(fetch_err), .align_err(align_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: "started" = past the post-reset idle cycle,
    // "have" = a word is held for decode, "kill" = next ack is stale.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_started, m_have, m_kill, m_err, m_align;
    int unsigned m_wait;

    function automatic void model_step();
        logic [31:0] p4, tgt;
        bit          take;
        int          off;
        if (!rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_ipc = 32'd0;
            m_started = 0; m_have = 0; m_kill = 0; m_err = 0; m_align = 0;
            m_wait = 0;
            return;
        end
        p4  = redir_pc + 32'd4;
        off = $signed(redir_imm);
        case (redir_type)
            2'd0:    tgt = p4 + 32'(off * 4);
            2'd1:    tgt = (p4 & 32'hF000_0000) | (32'(redir_target26) << 2);
            default: tgt = redir_reg & 32'hFFFF_FFFC;
        endcase
        take    = redir_valid && (redir_type != 2'd3);
        m_align = redir_valid && (redir_type == 2'd2) && ((redir_reg % 4) != 0);
        if (!m_started) begin
            m_started = 1;
            if (take) m_pc = tgt;
        end else if (m_have) begin
            m_wait = 0;
            if (take) begin m_pc = tgt; m_have = 0; end
            else if (instr_ready) m_have = 0;
        end else if (imem_ack) begin
            m_wait = 0;
            if (take) begin m_pc = tgt; m_kill = 0; end
            else if (m_kill) m_kill = 0;
            else begin
                m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_have = 1;
            end
        end else begin
            if (take) begin m_pc = tgt; m_kill = 1; end
            m_wait++;
            if (m_wait == TO) begin m_err = 1; m_wait = 0; end
        end
    endfunction

    // Apply one cycle of stimulus; returns at the following falling edge.
    task automatic drive(input logic ack, input logic rdy, input logic [31:0] data);
        imem_ack    = ack;
        instr_ready = rdy;
        imem_rdata  = data;
        @(posedge clk);
        model_step();
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    task automatic set_redir(input logic [1:0] t, input logic [31:0] rpc, input logic [15:0] imm,
                             input logic [25:0] t26, input logic [31:0] rr);
        redir_valid = 1'b1; redir_type = t; redir_pc = rpc;
        redir_imm = imm; redir_target26 = t26; redir_reg = rr;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redir_valid = 1'b0;
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h1234_5678);
        drive(1'b1, 1'b1, 32'h1234_5678);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_pc !== 32'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align_err: got %b want 0", align_err); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        // reset during an outstanding request: the ack must not complete
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'hDEAD_BEEF);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_midfetch_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_midfetch_instr: got %h want 0", instr); end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr = 32'd0;
        logic [31:0] exp_ipc  = 32'd0;
        int n_req = 0;
        int n_val = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (imem_req === 1'b1) begin
                n_req++;
                n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr: got %h want %h", imem_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (instr_valid === 1'b1) begin
                n_val++;
                n_checks++; if (instr_pc !== exp_ipc) begin n_fail++; $display("FAIL stream_instr_pc: got %h want %h", instr_pc, exp_ipc); end
                n_checks++; if (instr !== m_instr) begin n_fail++; $display("FAIL stream_instr: got %h want %h", instr, m_instr); end
                exp_ipc += 32'd4;
            end
            drive(imem_req, 1'b1, 32'hC000_0000 | 32'(i));
        end
        n_checks++; if (n_val !== 6) begin n_fail++; $display("FAIL stream_throughput: got %0d instrs want 6", n_val); end
        n_checks++; if (n_req !== 6) begin n_fail++; $display("FAIL stream_req_cycles: got %0d want 6", n_req); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL stall_req_held: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
            drive(i == 3, 1'b0, 32'hABCD_0001);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hABCD_0001 || instr_pc !== 32'd0) begin
                n_fail++; $display("FAIL stall_hold: got v=%b instr=%h pc=%h want v=1 instr=abcd0001 pc=0", instr_valid, instr, instr_pc);
            end
            drive(1'b0, i == 2, 32'd0);
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_next: got req=%b addr=%h v=%b want req=1 addr=4 v=0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_targets();
        do_reset();
        set_redir(2'b01, 32'hA000_0010, 16'd0, 26'h0000123, 32'd0);
        drive(1'b0, 1'b1, 32'd0);
        n_checks++; if (imem_addr !== 32'hA000_048C) begin n_fail++; $display("FAIL jump_target: got %h want a000048c", imem_addr); end
        drive(1'b1, 1'b1, 32'h1111_1111);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_stale_ack: got v=%b want 0", instr_valid); end
        set_redir(2'b00, 32'h0000_0100, 16'hFFFE, 26'd0, 32'd0);
        drive(1'b0, 1'b1, 32'd0);
        n_checks++; if (imem_addr !== 32'h0000_00FC) begin n_fail++; $display("FAIL branch_target: got %h want 000000fc", imem_addr); end
        drive(1'b1, 1'b1, 32'h2222_2222);
        drive(1'b1, 1'b0, 32'h3333_3333);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_00FC || instr !== 32'h3333_3333) begin
            n_fail++; $display("FAIL branch_deliver: got v=%b pc=%h instr=%h want 1 fc 33333333", instr_valid, instr_pc, instr);
        end
        set_redir(2'b11, 32'h5555_0000, 16'h0040, 26'h3FFFFFF, 32'h0000_8000);
        drive(1'b0, 1'b0, 32'd0);
        n_checks++; if (instr_valid !== 1'b1 || pc !== 32'h0000_0100) begin n_fail++; $display("FAIL type11_ignored: got v=%b pc=%h want 1 100", instr_valid, pc); end
        drive(1'b0, 1'b1, 32'd0);
        set_redir(2'b10, 32'd0, 16'd0, 26'd0, 32'h0000_0200);
        drive(1'b1, 1'b1, 32'h4444_4444);
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL ack_redir: got v=%b addr=%h want 0 200", instr_valid, imem_addr); end
        drive(1'b1, 1'b1, 32'h5555_5555);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0200 || instr !== 32'h5555_5555) begin
            n_fail++; $display("FAIL ack_redir_deliver: got v=%b pc=%h instr=%h want 1 200 55555555", instr_valid, instr_pc, instr);
        end
        drive(1'b0, 1'b1, 32'd0);
        set_redir(2'b10, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 32'd0);
        drive(1'b1, 1'b0, 32'h6666_6666);
        n_checks++; if (instr_pc !== 32'hFFFF_FFFC || pc !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got ipc=%h pc=%h want fffffffc 0", instr_pc, pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_redir(2'b10, 32'd0, 16'd0, 26'd0, 32'h0000_0300);
        drive(1'b0, 1'b1, 32'd0);
        set_redir(2'b10, 32'd0, 16'd0, 26'd0, 32'h0000_0400);
        drive(1'b0, 1'b1, 32'd0);
        n_checks++; if (imem_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL last_redir_wins: got %h want 400", imem_addr); end
        drive(1'b1, 1'b1, 32'h7777_0000);
        drive(1'b1, 1'b0, 32'h7777_7777);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0400 || instr !== 32'h7777_7777) begin
            n_fail++; $display("FAIL b2b_deliver: got v=%b pc=%h instr=%h want 1 400 77777777", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_jr_align();
        do_reset();
        set_redir(2'b10, 32'd0, 16'd0, 26'd0, 32'h0000_4003);
        drive(1'b0, 1'b1, 32'd0);
        n_checks++; if (align_err !== 1'b1 || imem_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL jr_align: got err=%b addr=%h want 1 4000", align_err, imem_addr); end
        drive(1'b1, 1'b1, 32'hBAD0_BAD0);
        n_checks++; if (align_err !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0000_4000) begin
            n_fail++; $display("FAIL jr_late_ack: got err=%b v=%b addr=%h want 0 0 4000", align_err, instr_valid, imem_addr);
        end
        drive(1'b1, 1'b1, 32'h0A0A_0A0A);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_4000 || instr !== 32'h0A0A_0A0A) begin
            n_fail++; $display("FAIL jr_deliver: got v=%b pc=%h instr=%h want 1 4000 0a0a0a0a", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        drive(1'b1, 1'b0, 32'h1357_9BDF);
        set_redir(2'b01, 32'h0000_1000, 16'd0, 26'h0000040, 32'd0);
        drive(1'b0, 1'b1, 32'd0);
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL hold_redir: got v=%b req=%b addr=%h want 0 1 100", instr_valid, imem_req, imem_addr);
        end
        drive(1'b1, 1'b0, 32'h2468_ACE0);
        n_checks++; if (instr_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL hold_redir_next: got %h want 100", instr_pc); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'd0);
            n_checks++; if (fetch_err !== (i + 1 >= int'(TO)) || imem_req !== 1'b1) begin
                n_fail++; $display("FAIL timeout_cycle%0d: got err=%b req=%b want err=%b req=1", i + 1, fetch_err, imem_req, i + 1 >= int'(TO));
            end
        end
        drive(1'b1, 1'b0, 32'hFACE_0001);
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hFACE_0001 || fetch_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_recover: got v=%b instr=%h err=%b want 1 face0001 1", instr_valid, instr, fetch_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            n_checks++; if (imem_req !== (m_started && !m_have)) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, m_started && !m_have); end
            if (m_started && !m_have) begin
                n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc); end
            end
            n_checks++; if (instr_valid !== m_have) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, instr_valid, m_have); end
            n_checks++; if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", i, instr, m_instr); end
            n_checks++; if (instr_pc !== m_ipc) begin n_fail++; $display("FAIL rnd_instr_pc@%0d: got %h want %h", i, instr_pc, m_ipc); end
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc, m_pc); end
            n_checks++; if (fetch_err !== m_err) begin n_fail++; $display("FAIL rnd_fetch_err@%0d: got %b want %b", i, fetch_err, m_err); end
            n_checks++; if (align_err !== m_align) begin n_fail++; $display("FAIL rnd_align_err@%0d: got %b want %b", i, align_err, m_align); end
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 4) == 0)
                set_redir(2'($urandom_range(0, 3)), $urandom, 16'($urandom), 26'($urandom), $urandom);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), $urandom);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        redir_valid = 1'b0; redir_type = 2'd0; redir_pc = 32'd0; redir_imm = 16'd0;
        redir_target26 = 26'd0; redir_reg = 32'd0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_targets();
        test_back_to_back();
        test_jr_align();
        test_redirect_hold();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the MIPS fetch stage. It owns the PC register and issues instruction-memory fetches with a req/ack handshake. It hands fetched words to decode with a valid/ready handshake. It computes redirect targets (branch, jump, jump-register); the jump target uses the same {PC+4[31:28], target26, 2'b00} formation as the existing shiftpc datapath block.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
TIMEOUT, 255, max cycles imem_req may stay unacknowledged before fetch_err (8-bit counter; legal range 1..255).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, equals pc while imem_req=1
imem_ack  in  1  memory accepted request, imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instruction available to decode
instr  out  32  instruction word
instr_pc  out  32  address of instr
instr_ready  in  1  decode consumes instr when instr_valid&instr_ready
redir_valid  in  1  one-cycle redirect request from execute
redir_type  in  2  00 branch, 01 jump, 10 jump-register, 11 ignored (no redirect)
redir_pc  in  32  address of redirecting instruction
redir_imm  in  16  branch offset (words, signed)
redir_target26  in  26  jump index field
redir_reg  in  32  jump-register value
pc  out  32  current PC register
fetch_err  out  1  sticky: fetch timeout occurred
align_err  out  1  one-cycle pulse: jr target misaligned

Behaviour:
- Reset (rst=0 at clk edge): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, kill=0, wait_cnt=0, fetch_err=0, align_err=0. Reset mid-fetch abandons the request; no handshake completes.
- States: IDLE, REQ, HOLD.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc. Request held until imem_ack (never withdrawn). On ack with kill=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go HOLD. On ack with kill=1: discard data, kill<=0, stay REQ (next request uses redirected pc, one idle cycle not required).
  - HOLD: instr_valid=1, instr/instr_pc stable until consumed. On instr_valid&instr_ready: go REQ.
- Latency: minimum fetch-to-valid is 1 cycle after ack; back-to-back throughput is 1 instruction per 2 cycles.
- Redirect targets (all mod 2^32):
  - p4 = redir_pc+4.
  - Branch: p4 + {{14{imm[15]}}, imm, 2'b00}.
  - Jump: {p4[31:28], target26, 2'b00}.
  - JR: {redir_reg[31:2], 2'b00}; if redir_reg[1:0]!=0, align_err=1 for one cycle.
  - Type 11: no effect.
- Redirect by state:
  - IDLE: pc<=target.
  - REQ, no ack this cycle: pc<=target, kill<=1.
  - REQ with same-cycle ack: data discarded, pc<=target, kill<=0, stay REQ.
  - HOLD: instr_valid drops next cycle, pc<=target, go REQ. A simultaneous instr_ready still counts as consumed.
- Back-to-back redirects: the last one wins.
- Timeout: wait_cnt counts cycles in REQ without ack, cleared on ack or leaving REQ. Reaching TIMEOUT sets fetch_err (sticky until reset), clears wait_cnt, and keeps requesting.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Test Plan:
1. Reset, ack same cycle as req, ready always 1 -> imem_addr 0,4,8,...; instr_pc matches; one instr per 2 cycles.
2. Ack delayed 3 cycles, ready low 2 cycles in HOLD -> imem_req held 4 cycles, addr stable; instr/instr_pc stable while stalled.
3. Jump, redir_pc=32'hA000_0010, target26=26'h0000123 -> next imem_addr 32'hA000_048C. Branch, redir_pc=32'h0000_0100, imm=16'hFFFE -> 32'h0000_00FC.
4. Redirect in REQ before ack (JR, redir_reg=32'h0000_4003) -> align_err pulses; late ack data never valid; next addr 32'h0000_4000.
5. Redirect with instr_ready in HOLD -> consumed once; next fetch at target, not pc+4.
6. TIMEOUT=4, no ack 10 cycles -> fetch_err high from cycle 4, stays 1; a later ack still delivers the instruction.
